sram_arbiter: RTL and testbench
===============================

// Module: sram_arbiter
// PURPOSE
//   Two-port arbiter/sequencer in front of the SRAM controller's 32-bit request interface.
//   Port 0 is the pipeline MEM stage; port 1 is the secondary master (loader/DMA).
//   Grants one request at a time and drives the controller's write/read enables for exactly one transaction.
//   Returns read data and a one-cycle ack to the granted port, and flags hung transactions via timeout.
// PARAMETERS
//   RR_EN           1   1 = round-robin between ports on contention; 0 = port 0 always wins
//   TIMEOUT_CYCLES  16  max BUSY cycles waiting for ctl_ready before abort (>= 8; counter width 8 bits)
// PORTS
//   clk         in   1   system clock, rising edge
//   rst         in   1   asynchronous, active-low reset
//   req0/req1   in   1   request from port 0/1; held high until ackN
//   we0/we1     in   1   1 = write (store), 0 = read (load)
//   addr0/addr1 in   32  word address (ALU result); only [17:0] reaches SRAM
//   wdata0/1    in   32  store data
//   ack0/ack1   out  1   one-cycle pulse: transaction of port N complete
//   rdata       out  32  registered load data; valid in ack cycle, held until next capture
//   stall0/1    out  1   reqN & ~ackN (combinational), freezes requester
//   err         out  1   one-cycle pulse with ackN when transaction timed out
//   err_sticky  out  1   set on any timeout, cleared only by reset
//   busy        out  1   high in BUSY and DONE
//   ctl_w_en    out  1   MEM_W_EN to SRAM controller
//   ctl_r_en    out  1   MEM_R_EN to SRAM controller
//   ctl_addr    out  32  ALU_res to controller (latched address)
//   ctl_wdata   out  32  ST_Value to controller (latched store data)
//   ctl_ready   in   1   Ready from controller
//   ctl_rdata   in   32  read_data from controller
// BEHAVIOUR
//   Reset (rst=0): state IDLE, all outputs 0, rdata=0, last_grant=1 (port 0 wins first), counter=0.
//   FSM states IDLE, BUSY, DONE; ctl_* enables are Moore outputs of state + latched we.
//   IDLE: if any req -> choose grant, latch we/addr/wdata of granted port, go BUSY.
//     Only one req -> that port. Both req: RR_EN=1 -> port != last_grant; RR_EN=0 -> port 0.
//     last_grant updated at grant time. No req -> stay IDLE, enables low.
//   BUSY: ctl_w_en=we_l, ctl_r_en=~we_l, ctl_addr/ctl_wdata from latches; counter increments.
//     ctl_ready=1 -> capture ctl_rdata into rdata (reads only; writes leave rdata unchanged), go DONE.
//     The controller's first BUSY cycle has Ready=0 because the enable is high, so no false completion.
//     counter == TIMEOUT_CYCLES-1 without ctl_ready -> go DONE with err flag; rdata <= 0.
//   DONE: enables low (the controller returns to its idle state here); ackN=1 for the granted port.
//     err=1 if aborted; counter cleared; -> IDLE.
//   Nominal latency: req sampled in IDLE at cycle 0 -> BUSY cycles 1..6 (ctl_ready in cycle 6) -> ack cycle 7.
//     Latency is the same for reads and writes. Earliest next grant is sampled in cycle 8.
//   Requester must drop reqN in the cycle after ackN; a req still high in IDLE is a new request.
//   Changes to addrN/wdataN after grant are ignored (latched).
//   Enables are never both high; enables are never high outside BUSY.
//   Reset mid-transaction: immediate return to IDLE with outputs 0; no ack is issued.
//     The SRAM controller shares the same reset source, inverted to its active-high rst.
//   Requests arriving while BUSY/DONE wait; stallN stays high for them.
// TESTING
//   1 Single read port0 addr=0x10; model returns 0xDEADBEEF -> ctl_r_en cycles 1-6, ack0 cycle 7, rdata=0xDEADBEEF.
//   2 Write port1 addr=0x20 wdata=0x12345678 -> ctl_w_en only, ctl_wdata=0x12345678, ack1 cycle 7, rdata unchanged.
//   3 req0 and req1 both high from reset, RR_EN=1 -> grant order 0,1,0,1 over 4 txns; RR_EN=0 -> port 0 until it drops.
//   4 Controller model never asserts ctl_ready -> after 16 BUSY cycles, ack+err pulse, err_sticky=1, rdata=0, FSM to IDLE.
//   5 rst low during BUSY cycle 3 -> enables 0 same cycle, no ack; after release, pending req0 is served from cycle 0 timing.
//   6 Change addr0 to 0x99 during BUSY -> ctl_addr stays the latched 0x10; stall0 high until ack0.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Request/response bundle between the two masters, the arbiter and the SRAM controller.
// The slave modport is the arbiter's view of the bundle; the master modport is the environment's view.
interface sram_arbiter_if;
  logic        req0;
  logic        req1;
  logic        we0;
  logic        we1;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata0;
  logic [31:0] wdata1;
  logic        ack0;
  logic        ack1;
  logic        stall0;
  logic        stall1;
  logic        err;
  logic        err_sticky;
  logic        busy;
  logic [31:0] rdata;
  logic        ctl_w_en;
  logic        ctl_r_en;
  logic [31:0] ctl_addr;
  logic [31:0] ctl_wdata;
  logic        ctl_ready;
  logic [31:0] ctl_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ctl_ready, ctl_rdata,
    output ack0, ack1, stall0, stall1, err, err_sticky, busy, rdata,
           ctl_w_en, ctl_r_en, ctl_addr, ctl_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ctl_ready, ctl_rdata,
    input  ack0, ack1, stall0, stall1, err, err_sticky, busy, rdata,
           ctl_w_en, ctl_r_en, ctl_addr, ctl_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of the SRAM controller: grants one transaction at a time,
// drives the controller enables while BUSY, and aborts hung transactions after a timeout.
module sram_arbiter #(
  parameter bit          RR_EN          = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  sram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        sticky_q, sticky_d;
  logic        wEn, rEn;

  // grant_q doubles as last_grant; resetting it to 1 lets port 0 win the first contention.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      grant_q  <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    sticky_d = sticky_q;
    wEn      = 1'b0;
    rEn      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          if (bus.req0 && bus.req1) begin
            grant_d = RR_EN ? ~grant_q : 1'b0;
          end else begin
            grant_d = bus.req1;
          end
          we_d    = grant_d ? bus.we1    : bus.we0;
          addr_d  = grant_d ? bus.addr1  : bus.addr0;
          wdata_d = grant_d ? bus.wdata1 : bus.wdata0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = BUSY;
        end
      end

      BUSY: begin
        wEn   = we_q;
        rEn   = ~we_q;
        cnt_d = cnt_q + 8'd1;
        if (bus.ctl_ready) begin
          if (!we_q) begin
            rdata_d = bus.ctl_rdata;
          end
          state_d = DONE;
        end else if (cnt_q == TimeoutLast) begin
          err_d    = 1'b1;
          sticky_d = 1'b1;
          rdata_d  = '0;
          state_d  = DONE;
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ctl_w_en   = wEn;
  assign bus.ctl_r_en   = rEn;
  assign bus.ctl_addr   = addr_q;
  assign bus.ctl_wdata  = wdata_q;
  assign bus.rdata      = rdata_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.ack0       = (state_q == DONE) && !grant_q;
  assign bus.ack1       = (state_q == DONE) &&  grant_q;
  assign bus.err        = (state_q == DONE) && err_q;
  assign bus.err_sticky = sticky_q;
  assign bus.stall0     = bus.req0 && !bus.ack0;
  assign bus.stall1     = bus.req1 && !bus.ack1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a round-robin instance and a fixed-priority instance,
// each behind a small SRAM controller model, with a per-instance expected-ack scoreboard.
module tb_sram_arbiter;

  typedef struct packed {
    logic        port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic clk;
  logic rstN;
  int   checks = 0;
  int   errors = 0;

  exp_t expA[$];
  exp_t expB[$];
  exp_t eA, eB;

  logic        hangA;
  logic [31:0] modelDataA;
  logic [31:0] modelDataB;
  logic [7:0]  enCntA, enCntB;

  sram_arbiter_if busA ();
  sram_arbiter_if busB ();

  sram_arbiter #(.RR_EN(1'b1), .TIMEOUT_CYCLES(16)) dutRr (
    .clk_i (clk),
    .rst_ni(rstN),
    .bus   (busA)
  );

  sram_arbiter #(.RR_EN(1'b0), .TIMEOUT_CYCLES(16)) dutFp (
    .clk_i (clk),
    .rst_ni(rstN),
    .bus   (busB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: Ready comes in the sixth consecutive enable cycle; read data depends on address.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      enCntA <= '0;
      enCntB <= '0;
    end else begin
      enCntA <= (busA.ctl_w_en || busA.ctl_r_en) ? enCntA + 8'd1 : 8'd0;
      enCntB <= (busB.ctl_w_en || busB.ctl_r_en) ? enCntB + 8'd1 : 8'd0;
    end
  end

  assign busA.ctl_ready = (busA.ctl_w_en || busA.ctl_r_en) && (enCntA == 8'd5) && !hangA;
  assign busB.ctl_ready = (busB.ctl_w_en || busB.ctl_r_en) && (enCntB == 8'd5);
  assign busA.ctl_rdata = modelDataA ^ busA.ctl_addr;
  assign busB.ctl_rdata = modelDataB ^ busB.ctl_addr;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic port, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata);
    if (port) begin
      busA.req1 = 1'b1; busA.we1 = we; busA.addr1 = addr; busA.wdata1 = wdata;
    end else begin
      busA.req0 = 1'b1; busA.we0 = we; busA.addr0 = addr; busA.wdata0 = wdata;
    end
  endtask

  task automatic waitAckA(input int limit, input logic [31:0] expAddr, input int changeAt,
                          input logic [31:0] newAddr, output int lat, output int rCyc,
                          output int wCyc, output int stallLow, output int addrBad);
    lat = limit; rCyc = 0; wCyc = 0; stallLow = 0; addrBad = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busA.ctl_r_en) rCyc++;
      if (busA.ctl_w_en) wCyc++;
      if (busA.busy && (busA.ctl_addr !== expAddr)) addrBad++;
      if ((busA.req0 && !busA.ack0 && !busA.stall0) || (busA.req1 && !busA.ack1 && !busA.stall1))
        stallLow++;
      if (i == changeAt) busA.addr0 = newAddr;
      if (busA.ack0 || busA.ack1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic waitAckB(input int limit, output int lat);
    lat = limit;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (busB.ack0 || busB.ack1) begin
        lat = i;
        break;
      end
    end
  endtask

  // Scoreboard and invariant monitors, one per instance.
  always @(negedge clk) begin
    if (rstN) begin
      checkOutput("A_en_exclusive", 32'(busA.ctl_w_en & busA.ctl_r_en), 32'd0);
      checkOutput("A_en_outside_busy", 32'((busA.ctl_w_en | busA.ctl_r_en) & ~busA.busy), 32'd0);
      if (busA.ack0 || busA.ack1) begin
        if (expA.size() == 0) begin
          checkOutput("A_unexpected_ack", 32'({busA.ack0, busA.ack1}), 32'd0);
        end else begin
          eA = expA.pop_front();
          checkOutput("A_ack_onehot", 32'(busA.ack0 & busA.ack1), 32'd0);
          checkOutput("A_ack_port", 32'(busA.ack1), 32'(eA.port));
          checkOutput("A_rdata", busA.rdata, eA.rdata);
          checkOutput("A_err", 32'(busA.err), 32'(eA.err));
        end
      end else begin
        checkOutput("A_err_no_ack", 32'(busA.err), 32'd0);
      end
    end
  end

  always @(negedge clk) begin
    if (rstN) begin
      checkOutput("B_en_exclusive", 32'(busB.ctl_w_en & busB.ctl_r_en), 32'd0);
      if (busB.ack0 || busB.ack1) begin
        if (expB.size() == 0) begin
          checkOutput("B_unexpected_ack", 32'({busB.ack0, busB.ack1}), 32'd0);
        end else begin
          eB = expB.pop_front();
          checkOutput("B_ack_port", 32'(busB.ack1), 32'(eB.port));
          checkOutput("B_rdata", busB.rdata, eB.rdata);
        end
      end
    end
  end

  initial begin
    int lat, rCyc, wCyc, stallLow, addrBad;

    rstN = 1'b0;
    hangA = 1'b0;
    modelDataA = 32'hDEADBEEF ^ 32'h10;
    modelDataB = 32'hA5A5A5A5;
    busA.req0 = 0; busA.req1 = 0; busA.we0 = 0; busA.we1 = 0;
    busA.addr0 = 0; busA.addr1 = 0; busA.wdata0 = 0; busA.wdata1 = 0;
    busB.req0 = 0; busB.req1 = 0; busB.we0 = 0; busB.we1 = 0;
    busB.addr0 = 0; busB.addr1 = 0; busB.wdata0 = 0; busB.wdata1 = 0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", 32'(busA.busy), 32'd0);
    checkOutput("reset_ack", 32'({busA.ack0, busA.ack1}), 32'd0);
    checkOutput("reset_enables", 32'({busA.ctl_w_en, busA.ctl_r_en}), 32'd0);
    checkOutput("reset_rdata", busA.rdata, 32'd0);
    checkOutput("reset_ctl_addr", busA.ctl_addr, 32'd0);
    checkOutput("reset_err_sticky", 32'(busA.err_sticky), 32'd0);
    rstN = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single read on port 0");
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    expA.push_back('{port: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    waitAckA(30, 32'h10, -1, 32'h0, lat, rCyc, wCyc, stallLow, addrBad);
    checkOutput("t1_latency", 32'(lat), 32'd7);
    checkOutput("t1_r_en_cycles", 32'(rCyc), 32'd6);
    checkOutput("t1_w_en_cycles", 32'(wCyc), 32'd0);
    checkOutput("t1_stall", 32'(stallLow), 32'd0);
    @(posedge clk); #1;
    busA.req0 = 1'b0;
    repeat (2) @(posedge clk); #1;
    checkOutput("t1_rdata_held", busA.rdata, 32'hDEADBEEF);

    $display("[TB] single write on port 1");
    applyStimulus(1'b1, 1'b1, 32'h20, 32'h12345678);
    expA.push_back('{port: 1'b1, rdata: 32'hDEADBEEF, err: 1'b0});
    waitAckA(30, 32'h20, -1, 32'h0, lat, rCyc, wCyc, stallLow, addrBad);
    checkOutput("t2_latency", 32'(lat), 32'd7);
    checkOutput("t2_w_en_cycles", 32'(wCyc), 32'd6);
    checkOutput("t2_r_en_cycles", 32'(rCyc), 32'd0);
    checkOutput("t2_ctl_wdata", busA.ctl_wdata, 32'h12345678);
    checkOutput("t2_addr", 32'(addrBad), 32'd0);
    @(posedge clk); #1;
    busA.req1 = 1'b0;
    @(posedge clk); #1;

    $display("[TB] round-robin contention");
    busA.we0 = 0; busA.addr0 = 32'h100; busA.req0 = 1'b1;
    busA.we1 = 0; busA.addr1 = 32'h200; busA.req1 = 1'b1;
    for (int t = 0; t < 4; t++) begin
      expA.push_back('{port: t[0], rdata: modelDataA ^ (t[0] ? 32'h200 : 32'h100), err: 1'b0});
    end
    for (int t = 0; t < 4; t++) begin
      waitAckA(30, t[0] ? 32'h200 : 32'h100, -1, 32'h0, lat, rCyc, wCyc, stallLow, addrBad);
      checkOutput("t3_rr_latency", 32'(lat), 32'd7);
      checkOutput("t3_rr_stall", 32'(stallLow), 32'd0);
      checkOutput("t3_rr_addr", 32'(addrBad), 32'd0);
      @(posedge clk); #1;
    end
    busA.req0 = 1'b0; busA.req1 = 1'b0;
    @(posedge clk); #1;

    $display("[TB] fixed-priority contention");
    busB.addr0 = 32'h1; busB.req0 = 1'b1;
    busB.addr1 = 32'h2; busB.req1 = 1'b1;
    expB.push_back('{port: 1'b0, rdata: modelDataB ^ 32'h1, err: 1'b0});
    expB.push_back('{port: 1'b0, rdata: modelDataB ^ 32'h1, err: 1'b0});
    expB.push_back('{port: 1'b1, rdata: modelDataB ^ 32'h2, err: 1'b0});
    for (int t = 0; t < 3; t++) begin
      waitAckB(30, lat);
      checkOutput("t3_fp_latency", 32'(lat), 32'd7);
      @(posedge clk); #1;
      if (t == 1) busB.req0 = 1'b0;
      if (t == 2) busB.req1 = 1'b0;
    end

    $display("[TB] controller never ready");
    hangA = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h30, 32'h0);
    expA.push_back('{port: 1'b0, rdata: 32'h0, err: 1'b1});
    waitAckA(40, 32'h30, -1, 32'h0, lat, rCyc, wCyc, stallLow, addrBad);
    checkOutput("t4_latency", 32'(lat), 32'd17);
    checkOutput("t4_r_en_cycles", 32'(rCyc), 32'd16);
    @(posedge clk); #1;
    busA.req0 = 1'b0;
    hangA = 1'b0;
    checkOutput("t4_idle_after_abort", 32'(busA.busy), 32'd0);
    checkOutput("t4_err_sticky", 32'(busA.err_sticky), 32'd1);
    applyStimulus(1'b1, 1'b0, 32'h40, 32'h0);
    expA.push_back('{port: 1'b1, rdata: modelDataA ^ 32'h40, err: 1'b0});
    waitAckA(30, 32'h40, -1, 32'h0, lat, rCyc, wCyc, stallLow, addrBad);
    checkOutput("t4_recover_latency", 32'(lat), 32'd7);
    @(posedge clk); #1;
    busA.req1 = 1'b0;
    checkOutput("t4_err_sticky_kept", 32'(busA.err_sticky), 32'd1);

    $display("[TB] address change after grant");
    applyStimulus(1'b0, 1'b0, 32'h10, 32'h0);
    expA.push_back('{port: 1'b0, rdata: 32'hDEADBEEF, err: 1'b0});
    waitAckA(30, 32'h10, 3, 32'h99, lat, rCyc, wCyc, stallLow, addrBad);
    checkOutput("t6_latency", 32'(lat), 32'd7);
    checkOutput("t6_addr_latched", 32'(addrBad), 32'd0);
    checkOutput("t6_stall", 32'(stallLow), 32'd0);
    @(posedge clk); #1;
    busA.req0 = 1'b0;
    @(posedge clk); #1;

    $display("[TB] reset during BUSY");
    applyStimulus(1'b0, 1'b0, 32'h50, 32'h0);
    repeat (4) @(negedge clk);
    rstN = 1'b0;
    #1;
    checkOutput("t5_enables_in_reset", 32'({busA.ctl_w_en, busA.ctl_r_en}), 32'd0);
    checkOutput("t5_busy_in_reset", 32'(busA.busy), 32'd0);
    checkOutput("t5_ack_in_reset", 32'({busA.ack0, busA.ack1}), 32'd0);
    checkOutput("t5_rdata_in_reset", busA.rdata, 32'd0);
    checkOutput("t5_sticky_cleared", 32'(busA.err_sticky), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rstN = 1'b1;
    expA.push_back('{port: 1'b0, rdata: modelDataA ^ 32'h50, err: 1'b0});
    waitAckA(30, 32'h50, -1, 32'h0, lat, rCyc, wCyc, stallLow, addrBad);
    checkOutput("t5_latency_after_reset", 32'(lat), 32'd7);
    checkOutput("t5_r_en_cycles", 32'(rCyc), 32'd6);
    @(posedge clk); #1;
    busA.req0 = 1'b0;
    repeat (3) @(posedge clk); #1;

    checkOutput("scoreboard_A_drained", 32'(expA.size()), 32'd0);
    checkOutput("scoreboard_B_drained", 32'(expB.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
